// File: rtl/mipi_pkg.sv
// ============================================================================
// Module      : mipi_pkg
// Description : Shared constants, FSM encoding and centring helper for the
//               MIPI data-lane delay calibrator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mipi_pkg;

    localparam int TAP_W = 5;
    localparam int TAP_N = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SETTLE  = 3'd2,
        MEASURE = 3'd3,
        EVAL    = 3'd4,
        CENTER  = 3'd5,
        FINISH  = 3'd6
    } cal_state_t;

    // Middle of the best run, rounding toward the earlier tap for even lengths.
    function automatic logic [TAP_W-1:0] center_tap(input logic [TAP_W-1:0] run_start,
                                                    input logic [TAP_W:0]   run_len);
        if (run_len == '0)
            return '0;
        return run_start + TAP_W'((run_len - 1'b1) >> 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mipi_hit_window.sv
// ============================================================================
// Module      : mipi_hit_window
// Description : Saturating 8-bit sync-hit counter, cleared per tap and
//               enabled only during the measurement window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mipi_hit_window (
    input  logic       clk,
    input  logic       resetb,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       hit_i,
    output logic [7:0] hits_o
);

    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && hit_i && (cnt_q != 8'hFF)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign hits_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/mipi_delay_cal.sv
// ============================================================================
// Module      : mipi_delay_cal
// Description : Sweeps all 32 delay taps, finds the longest passing run of
//               sync hits and loads its centre. Optional pass map under
//               macro MIPI_CAL_MAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mipi_delay_cal
    import mipi_pkg::*;
#(
    parameter int SETTLE_CYC = 16,
    parameter int WINDOW_CYC = 1024,
    parameter int MIN_HITS   = 4
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             start,
    input  logic             sync_hit,
    output logic             del_ld,
    output logic [TAP_W-1:0] del_val,
    output logic             busy,
    output logic             done,
    output logic             cal_ok,
    output logic [TAP_W-1:0] best_tap,
    output logic [TAP_W:0]   eye_width
`ifdef MIPI_CAL_MAP_EN
    ,
    output logic [TAP_N-1:0] pass_map
`endif
);

    localparam int CYC_MAX = (WINDOW_CYC > SETTLE_CYC) ? WINDOW_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(CYC_MAX) + 1;
    localparam logic [CNT_W-1:0] c_SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] c_WINDOW_LAST = CNT_W'(WINDOW_CYC - 1);
    localparam logic [7:0]       c_MIN_HITS    = 8'(MIN_HITS);
    localparam logic [TAP_W-1:0] c_LAST_TAP    = TAP_W'(TAP_N - 1);

    cal_state_t       state_q, state_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [TAP_W:0]   cur_len_q, cur_len_d, best_len_q, best_len_d;
    logic [TAP_W-1:0] cur_start_q, cur_start_d, best_start_q, best_start_d;
    logic [TAP_W-1:0] best_tap_q, best_tap_d, del_val_q, del_val_d;
    logic [TAP_W:0]   eye_width_q, eye_width_d;
    logic             del_ld_q, del_ld_d, done_q, done_d, cal_ok_q, cal_ok_d;
`ifdef MIPI_CAL_MAP_EN
    logic [TAP_N-1:0] pass_map_q, pass_map_d;
`endif

    logic             w_hit_clr;
    logic             w_hit_en;
    logic [7:0]       w_hits;
    logic             w_pass;

    mipi_hit_window u_hit_window (
        .clk    (clk),
        .resetb (resetb),
        .clr_i  (w_hit_clr),
        .en_i   (w_hit_en),
        .hit_i  (sync_hit),
        .hits_o (w_hits)
    );

    assign w_pass = (w_hits >= c_MIN_HITS);

    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        cyc_d        = cyc_q;
        cur_len_d    = cur_len_q;
        cur_start_d  = cur_start_q;
        best_len_d   = best_len_q;
        best_start_d = best_start_q;
        best_tap_d   = best_tap_q;
        eye_width_d  = eye_width_q;
        cal_ok_d     = cal_ok_q;
        del_val_d    = del_val_q;
        del_ld_d     = 1'b0;
        done_d       = 1'b0;
        w_hit_clr    = 1'b0;
        w_hit_en     = 1'b0;
`ifdef MIPI_CAL_MAP_EN
        pass_map_d   = pass_map_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    tap_d        = '0;
                    cur_len_d    = '0;
                    cur_start_d  = '0;
                    best_len_d   = '0;
                    best_start_d = '0;
                    del_val_d    = '0;
                    del_ld_d     = 1'b1;
`ifdef MIPI_CAL_MAP_EN
                    pass_map_d   = '0;
`endif
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                w_hit_clr = 1'b1;
                state_d   = SETTLE;
            end
            SETTLE: begin
                if (cyc_q == c_SETTLE_LAST) begin
                    cyc_d   = '0;
                    state_d = MEASURE;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            MEASURE: begin
                w_hit_en = 1'b1;
                if (cyc_q == c_WINDOW_LAST) begin
                    cyc_d   = '0;
                    state_d = EVAL;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            EVAL: begin
                if (w_pass) begin
                    if (cur_len_q == '0)
                        cur_start_d = tap_q;
                    cur_len_d = cur_len_q + 1'b1;
                end else begin
                    cur_len_d = '0;
                end
                // Strict compare: an equal-length later run never displaces the first.
                if (cur_len_d > best_len_q) begin
                    best_len_d   = cur_len_d;
                    best_start_d = cur_start_d;
                end
`ifdef MIPI_CAL_MAP_EN
                pass_map_d[tap_q] = w_pass;
`endif
                del_ld_d = 1'b1;
                if (tap_q == c_LAST_TAP) begin
                    best_tap_d = center_tap(best_start_d, best_len_d);
                    del_val_d  = best_tap_d;
                    state_d    = CENTER;
                end else begin
                    tap_d     = tap_q + 1'b1;
                    del_val_d = tap_d;
                    state_d   = LOAD;
                end
            end
            CENTER: begin
                state_d = FINISH;
            end
            FINISH: begin
                done_d      = 1'b1;
                cal_ok_d    = (best_len_q != '0);
                eye_width_d = best_len_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q      <= IDLE;
            tap_q        <= '0;
            cyc_q        <= '0;
            cur_len_q    <= '0;
            cur_start_q  <= '0;
            best_len_q   <= '0;
            best_start_q <= '0;
            best_tap_q   <= '0;
            eye_width_q  <= '0;
            cal_ok_q     <= 1'b0;
            del_val_q    <= '0;
            del_ld_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            cyc_q        <= cyc_d;
            cur_len_q    <= cur_len_d;
            cur_start_q  <= cur_start_d;
            best_len_q   <= best_len_d;
            best_start_q <= best_start_d;
            best_tap_q   <= best_tap_d;
            eye_width_q  <= eye_width_d;
            cal_ok_q     <= cal_ok_d;
            del_val_q    <= del_val_d;
            del_ld_q     <= del_ld_d;
            done_q       <= done_d;
        end
    end

`ifdef MIPI_CAL_MAP_EN
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)
            pass_map_q <= '0;
        else
            pass_map_q <= pass_map_d;
    end

    assign pass_map = pass_map_q;
`endif

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign del_ld    = del_ld_q;
    assign del_val   = del_val_q;
    assign cal_ok    = cal_ok_q;
    assign best_tap  = best_tap_q;
    assign eye_width = eye_width_q;

endmodule

`default_nettype wire

// File: tb/tb_mipi_delay_cal.sv
// ============================================================================
// Module      : tb_mipi_delay_cal
// Description : Directed lock-step bench for mipi_delay_cal with a result
//               scoreboard; checks pass_map when MIPI_CAL_MAP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mipi_delay_cal;
    import mipi_pkg::*;

    localparam int SETTLE = 4;
    localparam int WINDOW = 16;
    localparam int MINH   = 4;

    logic             clk      = 1'b0;
    logic             resetb   = 1'b0;
    logic             start    = 1'b0;
    logic             sync_hit = 1'b0;
    logic             del_ld;
    logic [TAP_W-1:0] del_val;
    logic             busy;
    logic             done;
    logic             cal_ok;
    logic [TAP_W-1:0] best_tap;
    logic [TAP_W:0]   eye_width;
`ifdef MIPI_CAL_MAP_EN
    logic [TAP_N-1:0] pass_map;
`endif

    typedef struct {
        logic [TAP_W-1:0] tap;
        logic [TAP_W:0]   width;
        logic             ok;
        logic [TAP_N-1:0] map;
    } exp_t;

    exp_t sb[$];
    int   hits_tbl[TAP_N];
    bit   settle_inj = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    mipi_delay_cal #(
        .SETTLE_CYC (SETTLE),
        .WINDOW_CYC (WINDOW),
        .MIN_HITS   (MINH)
    ) dut (
        .clk       (clk),
        .resetb    (resetb),
        .start     (start),
        .sync_hit  (sync_hit),
        .del_ld    (del_ld),
        .del_val   (del_val),
        .busy      (busy),
        .done      (done),
        .cal_ok    (cal_ok),
        .best_tap  (best_tap),
        .eye_width (eye_width)
`ifdef MIPI_CAL_MAP_EN
        ,
        .pass_map  (pass_map)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_hits(input int lo, input int hi, input int n);
        for (int t = lo; t <= hi; t++)
            hits_tbl[t] = n;
    endtask

    // Reference: longest run of passing taps, first run wins ties.
    function automatic exp_t model();
        exp_t e;
        int   cur = 0;
        int   best = 0;
        int   bs = 0;
        int   cs = 0;
        e.map = '0;
        for (int t = 0; t < TAP_N; t++) begin
            if (hits_tbl[t] >= MINH) begin
                if (cur == 0)
                    cs = t;
                cur++;
                e.map[t] = 1'b1;
            end else begin
                cur = 0;
            end
            if (cur > best) begin
                best = cur;
                bs   = cs;
            end
        end
        e.width = (TAP_W + 1)'(best);
        e.ok    = (best != 0);
        e.tap   = (best == 0) ? '0 : TAP_W'(bs + (best - 1) / 2);
        return e;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},  busy,      0);
        chk({tag, "_done"},  done,      0);
        chk({tag, "_ld"},    del_ld,    0);
        chk({tag, "_val"},   del_val,   0);
        chk({tag, "_ok"},    cal_ok,    0);
        chk({tag, "_tap"},   best_tap,  0);
        chk({tag, "_width"}, eye_width, 0);
`ifdef MIPI_CAL_MAP_EN
        chk({tag, "_map"},   pass_map,  0);
`endif
    endtask

    task automatic run_sweep(input int abort_tap);
        exp_t e;
        exp_t got;
        e = model();
        sb.push_back(e);
        start = 1'b1;
        for (int t = 0; t < TAP_N; t++) begin
            step();
            start    = 1'b0;
            sync_hit = 1'b0;
            chk("load_strobe", del_ld, 1);
            chk("load_val", del_val, t);
            chk("load_busy", busy, 1);
            for (int i = 0; i < SETTLE; i++) begin
                step();
                if (i == 0)
                    chk("settle_ld_low", del_ld, 0);
                sync_hit = settle_inj;
                start    = (t == 3 && i == 0);
            end
            for (int i = 0; i < WINDOW; i++) begin
                step();
                start    = 1'b0;
                sync_hit = (i >= WINDOW - hits_tbl[t]);
                if (t == abort_tap && i == WINDOW / 2) begin
                    resetb = 1'b0;
                    #1;
                    check_all_zero("abort");
                    void'(sb.pop_back());
                    sync_hit = 1'b0;
                    step();
                    step();
                    resetb = 1'b1;
                    step();
                    chk("abort_idle_busy", busy, 0);
                    return;
                end
            end
            step();
            sync_hit = 1'b0;
        end
        step();
        chk("center_ld", del_ld, 1);
        chk("center_val", del_val, e.tap);
        chk("center_busy", busy, 1);
        step();
        chk("finish_done_low", done, 0);
        chk("finish_busy", busy, 1);
        step();
        chk("done_pulse", done, 1);
        chk("done_busy_low", busy, 0);
        chk("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
            got = sb.pop_front();
            chk("best_tap", best_tap, got.tap);
            chk("eye_width", eye_width, got.width);
            chk("cal_ok", cal_ok, got.ok);
`ifdef MIPI_CAL_MAP_EN
            chk("pass_map", pass_map, got.map);
`endif
        end
        step();
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        repeat (3) step();
        check_all_zero("reset");
        resetb = 1'b1;
        step();
        chk("idle_busy", busy, 0);

        // Single run 10..20
        set_hits(0, TAP_N - 1, 0);
        set_hits(10, 20, 8);
        run_sweep(-1);

        // Two equal runs: earlier one is chosen
        set_hits(0, TAP_N - 1, 0);
        set_hits(2, 5, 8);
        set_hits(20, 23, 8);
        run_sweep(-1);

        // No hits anywhere
        set_hits(0, TAP_N - 1, 0);
        run_sweep(-1);

        // Every tap passes, hit on every window cycle including the last
        set_hits(0, TAP_N - 1, WINDOW);
        run_sweep(-1);

        // Threshold edge: 3 hits fail, 4 pass; settle-phase hits must not count
        set_hits(0, TAP_N - 1, 0);
        set_hits(0, 9, 3);
        set_hits(12, 14, 4);
        settle_inj = 1'b1;
        run_sweep(-1);
        settle_inj = 1'b0;

        // Reset during tap 7 measurement, then a clean sweep
        set_hits(0, TAP_N - 1, 0);
        set_hits(10, 20, 8);
        run_sweep(-1);
        run_sweep(7);
        run_sweep(-1);

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
